// File: rtl/miller_frame_detect.sv
// Modified-Miller (ISO 14443-A, 106 kbit/s) pause-stream frame detector.
// Classifies each ETU as X/Y/Z from pause-edge phase, then decodes SoF, data bits and EoF.
module miller_frame_detect #(
  parameter int CLK_PER_ETU = 32,
  parameter int TOL         = 3,
  parameter int CNT_W       = 9
) (
  input  logic             in_clk,
  input  logic             in_PoR,
  input  logic             in_pause,
  input  logic             in_en,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_frame_active,
  output logic             out_bit_valid,
  output logic             out_bit,
  output logic             out_err,
  output logic [CNT_W-1:0] out_bit_count
);
  localparam int HALF = CLK_PER_ETU / 2;
  localparam int PH_W = $clog2(CLK_PER_ETU);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_PER_ETU - 1);
  localparam logic [PH_W-1:0] PH_ZMAX = PH_W'(TOL);
  localparam logic [PH_W-1:0] PH_XMIN = PH_W'(HALF - TOL);
  localparam logic [PH_W-1:0] PH_XMAX = PH_W'(HALF + TOL);
  localparam logic [PH_W-1:0] PH_X1   = PH_W'(HALF + 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_DATA} state_t;
  typedef enum logic [1:0] {SYM_X, SYM_Y, SYM_Z} sym_t;

  state_t          r_state, w_nstate;
  sym_t            r_prev_sym, w_sym;
  logic [PH_W-1:0] r_ph;
  logic            r_zseen, r_xseen, r_pause_prev;
  logic            w_edge, w_edge_z, w_edge_x, w_decide;
  logic            w_ev_sof, w_ev_eof, w_ev_bit, w_bit_val, w_ev_err;

  assign w_edge   = in_pause & ~r_pause_prev;
  assign w_edge_z = w_edge && (r_ph <= PH_ZMAX);
  assign w_edge_x = w_edge && (r_ph >= PH_XMIN) && (r_ph <= PH_XMAX);
  assign w_decide = (r_state != ST_IDLE) && (r_ph == PH_LAST);

  // Accepted edges re-align the phase so the edge cycle counts as nominal 0 or HALF.
  always_ff @(posedge in_clk or posedge in_PoR) begin
    if (in_PoR) begin
      r_state      <= ST_IDLE;
      r_ph         <= '0;
      r_zseen      <= 1'b0;
      r_xseen      <= 1'b0;
      r_prev_sym   <= SYM_Z;
      r_pause_prev <= 1'b1;
    end else begin
      r_state      <= w_nstate;
      r_pause_prev <= in_pause;
      if (w_nstate == ST_IDLE) begin
        r_ph    <= '0;
        r_zseen <= 1'b0;
        r_xseen <= 1'b0;
      end else if (w_decide) begin
        r_ph       <= '0;
        r_zseen    <= 1'b0;
        r_xseen    <= 1'b0;
        r_prev_sym <= w_sym;
      end else if (w_edge_z) begin
        r_ph    <= PH_ONE;
        r_zseen <= 1'b1;
      end else if (w_edge_x) begin
        r_ph    <= PH_X1;
        r_xseen <= 1'b1;
      end else begin
        r_ph <= r_ph + PH_ONE;
      end
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_sym     = SYM_Y;
    w_ev_sof  = 1'b0;
    w_ev_eof  = 1'b0;
    w_ev_bit  = 1'b0;
    w_bit_val = 1'b0;
    w_ev_err  = 1'b0;
    if (r_xseen)      w_sym = SYM_X;
    else if (r_zseen) w_sym = SYM_Z;
    case (r_state)
      ST_IDLE: if (in_en && w_edge) w_nstate = ST_SOF;
      ST_SOF, ST_DATA: begin
        if (!in_en) begin
          w_nstate = ST_IDLE;
        end else if (w_edge && !w_edge_z && !w_edge_x) begin
          w_ev_err = 1'b1;
        end else if (w_decide) begin
          if (r_xseen && r_zseen) begin
            w_ev_err = 1'b1;
          end else if (r_state == ST_SOF) begin
            if (w_sym == SYM_Z) begin
              w_ev_sof = 1'b1;
              w_nstate = ST_DATA;
            end else begin
              w_ev_err = 1'b1;
            end
          end else begin
            case (w_sym)
              SYM_X: begin
                w_ev_bit  = 1'b1;
                w_bit_val = 1'b1;
              end
              SYM_Z: begin
                if (r_prev_sym == SYM_X) w_ev_err = 1'b1;
                else                     w_ev_bit = 1'b1;
              end
              default: begin
                if (r_prev_sym == SYM_X) begin
                  w_ev_bit = 1'b1;
                end else begin
                  w_ev_eof = 1'b1;
                  w_nstate = ST_IDLE;
                end
              end
            endcase
            // A saturated counter turns the would-be bit into an error.
            if (w_ev_bit && (&out_bit_count)) begin
              w_ev_bit  = 1'b0;
              w_bit_val = 1'b0;
              w_ev_err  = 1'b1;
            end
          end
        end
        if (w_ev_err) w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_PoR) begin
    if (in_PoR) begin
      out_sof          <= 1'b0;
      out_eof          <= 1'b0;
      out_frame_active <= 1'b0;
      out_bit_valid    <= 1'b0;
      out_bit          <= 1'b0;
      out_err          <= 1'b0;
      out_bit_count    <= '0;
    end else begin
      out_sof       <= w_ev_sof;
      out_eof       <= w_ev_eof;
      out_err       <= w_ev_err;
      out_bit_valid <= w_ev_bit;
      if (w_ev_bit) out_bit <= w_bit_val;
      if (w_ev_sof) begin
        out_frame_active <= 1'b1;
        out_bit_count    <= '0;
      end else if (w_nstate == ST_IDLE) begin
        out_frame_active <= 1'b0;
      end
      if (w_ev_bit) out_bit_count <= out_bit_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_miller_frame_detect.sv
// Directed bench for miller_frame_detect: table of pause schedules with expected
// event cycles, plus hand-written mid-frame reset and counter-overflow sequences.
module tb_miller_frame_detect;
  localparam int CPE = 32;
  localparam int TL  = 3;
  localparam int CW  = 9;

  logic clk = 1'b0, por = 1'b1, pause = 1'b0, en = 1'b0;
  logic sof, eof, act, bvld, bval, err;
  logic [CW-1:0] cnt;

  miller_frame_detect #(.CLK_PER_ETU(CPE), .TOL(TL), .CNT_W(CW)) dut (
    .in_clk(clk), .in_PoR(por), .in_pause(pause), .in_en(en),
    .out_sof(sof), .out_eof(eof), .out_frame_active(act),
    .out_bit_valid(bvld), .out_bit(bval), .out_err(err), .out_bit_count(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    np;
    int    p[4];
    int    hi_until;
    int    en_off;
    int    e_sof;
    int    e_eof;
    int    e_err;
    int    nb;
    int    bc[5];
    int    bv[5];
    int    e_cnt;
  } vec_t;

  vec_t vecs[12];
  int   n_pass = 0, n_tot = 0, cyc = 0;
  int   sof_q[$], eof_q[$], err_q[$], bc_q[$], bv_q[$];
  logic act_log[20000];

  task automatic chk(input string nm, input int a, input int e);
    n_tot++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, a, e);
  endtask

  task automatic clear_logs();
    sof_q.delete(); eof_q.delete(); err_q.delete(); bc_q.delete(); bv_q.delete();
  endtask

  // Log this cycle's outputs, apply this cycle's inputs, advance one clock.
  task automatic step(input logic p, input logic e);
    pause = p;
    en    = e;
    if (sof)  sof_q.push_back(cyc);
    if (eof)  eof_q.push_back(cyc);
    if (err)  err_q.push_back(cyc);
    if (bvld) begin bc_q.push_back(cyc); bv_q.push_back(int'(bval)); end
    act_log[cyc] = act;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input logic p0);
    por   = 1'b1;
    pause = p0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    por = 1'b0;
    cyc = 0;
    clear_logs();
  endtask

  task automatic run_vec(input vec_t v);
    for (int c = 0; c < 400; c++) begin
      logic p, e;
      p = (c < v.hi_until);
      for (int i = 0; i < v.np; i++)
        if (c >= v.p[i] && c < v.p[i] + 3) p = 1'b1;
      e = !(v.en_off >= 0 && c >= v.en_off);
      step(p, e);
    end
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, ":sof_n"}, sof_q.size(), (v.e_sof >= 0) ? 1 : 0);
    chk({v.name, ":sof_cyc"}, (sof_q.size() > 0) ? sof_q[0] : -1, v.e_sof);
    chk({v.name, ":eof_n"}, eof_q.size(), (v.e_eof >= 0) ? 1 : 0);
    chk({v.name, ":eof_cyc"}, (eof_q.size() > 0) ? eof_q[0] : -1, v.e_eof);
    chk({v.name, ":err_n"}, err_q.size(), (v.e_err >= 0) ? 1 : 0);
    chk({v.name, ":err_cyc"}, (err_q.size() > 0) ? err_q[0] : -1, v.e_err);
    chk({v.name, ":bits_n"}, bc_q.size(), v.nb);
    for (int i = 0; i < v.nb; i++) begin
      chk({v.name, ":bit_cyc"}, (i < bc_q.size()) ? bc_q[i] : -1, v.bc[i]);
      chk({v.name, ":bit_val"}, (i < bv_q.size()) ? bv_q[i] : -1, v.bv[i]);
    end
    chk({v.name, ":count"}, int'(cnt), v.e_cnt);
    chk({v.name, ":active_end"}, int'(act), 0);
    if (v.e_sof >= 0) chk({v.name, ":active_at_sof"}, int'(act_log[v.e_sof]), 1);
    if (v.e_eof >= 0) begin
      chk({v.name, ":active_at_eof"}, int'(act_log[v.e_eof]), 0);
      chk({v.name, ":active_pre_eof"}, int'(act_log[v.e_eof - 1]), 1);
    end
    if (v.en_off >= 0) chk({v.name, ":active_en_off"}, int'(act_log[v.en_off + 1]), 0);
  endtask

  initial begin
    //          name            np  pauses               hi  en   sof  eof  err  nb  bit cycles                bit values      cnt
    vecs[0]  = '{"sof_xyx",     3, '{100,148,212,0},    0, -1, 132, 292,  -1, 4, '{164,196,228,260,0}, '{1,0,1,0,0}, 4};
    vecs[1]  = '{"sof_only",    1, '{100,0,0,0},        0, -1, 132, 164,  -1, 0, '{0,0,0,0,0},         '{0,0,0,0,0}, 0};
    vecs[2]  = '{"x_late_ok",   2, '{100,151,0,0},      0, -1, 132, 231,  -1, 2, '{167,199,0,0,0},     '{1,0,0,0,0}, 2};
    vecs[3]  = '{"x_late_bad",  2, '{100,152,0,0},      0, -1, 132,  -1, 153, 0, '{0,0,0,0,0},         '{0,0,0,0,0}, 0};
    vecs[4]  = '{"x_early_ok",  2, '{100,145,0,0},      0, -1, 132, 225,  -1, 2, '{161,193,0,0,0},     '{1,0,0,0,0}, 2};
    vecs[5]  = '{"x_early_bad", 2, '{100,144,0,0},      0, -1, 132,  -1, 145, 0, '{0,0,0,0,0},         '{0,0,0,0,0}, 0};
    vecs[6]  = '{"z_after_x",   3, '{100,148,164,0},    0, -1, 132,  -1, 196, 1, '{164,0,0,0,0},       '{1,0,0,0,0}, 1};
    vecs[7]  = '{"z_tol_ok",    2, '{100,135,0,0},      0, -1, 132, 199,  -1, 1, '{167,0,0,0,0},       '{0,0,0,0,0}, 1};
    vecs[8]  = '{"z_tol_bad",   2, '{100,136,0,0},      0, -1, 132,  -1, 137, 0, '{0,0,0,0,0},         '{0,0,0,0,0}, 0};
    vecs[9]  = '{"sof_not_z",   2, '{100,116,0,0},      0, -1,  -1,  -1, 132, 0, '{0,0,0,0,0},         '{0,0,0,0,0}, 0};
    vecs[10] = '{"pause_at_por",1, '{100,0,0,0},       20, -1, 132, 164,  -1, 0, '{0,0,0,0,0},         '{0,0,0,0,0}, 0};
    vecs[11] = '{"en_drop",     2, '{100,148,0,0},      0, 150, 132, -1,  -1, 0, '{0,0,0,0,0},         '{0,0,0,0,0}, 0};

    #23;
    chk("reset_outputs", int'({sof, eof, act, bvld, bval, err}), 0);
    chk("reset_count", int'(cnt), 0);

    for (int k = 0; k < 12; k++) begin
      do_reset(vecs[k].hi_until > 0);
      run_vec(vecs[k]);
      check_vec(vecs[k]);
    end

    // Power-on reset two bits into a frame, then a fresh frame.
    do_reset(1'b0);
    for (int c = 0; c < 200; c++)
      step((c >= 100 && c < 103) || (c >= 148 && c < 151), 1'b1);
    chk("por_mid:bits_before", bc_q.size(), 2);
    chk("por_mid:count_before", int'(cnt), 2);
    chk("por_mid:active_before", int'(act), 1);
    por = 1'b1;
    #1;
    chk("por_mid:outputs", int'({sof, eof, act, bvld, bval, err}), 0);
    chk("por_mid:count", int'(cnt), 0);
    chk("por_mid:no_eof", eof_q.size(), 0);
    chk("por_mid:no_err", err_q.size(), 0);
    do_reset(1'b0);
    run_vec(vecs[1]);
    check_vec(vecs[1]);

    // 511 ones fill the counter; the 512th bit is an overflow error.
    do_reset(1'b0);
    for (int c = 0; c < 16600; c++)
      step((c >= 100 && c < 103) ||
           (c >= 148 && ((c - 148) % 32) < 3 && ((c - 148) / 32) < 512), 1'b1);
    begin
      int ones;
      ones = 0;
      foreach (bv_q[i]) ones += bv_q[i];
      chk("ovf:sof_cyc", (sof_q.size() > 0) ? sof_q[0] : -1, 132);
      chk("ovf:bits_n", bc_q.size(), 511);
      chk("ovf:ones", ones, 511);
      chk("ovf:last_bit_cyc", (bc_q.size() > 0) ? bc_q[bc_q.size() - 1] : -1, 16484);
      chk("ovf:err_n", err_q.size(), 1);
      chk("ovf:err_cyc", (err_q.size() > 0) ? err_q[0] : -1, 16516);
      chk("ovf:eof_n", eof_q.size(), 0);
      chk("ovf:count", int'(cnt), 511);
      chk("ovf:active", int'(act), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
